// File: rtl/cipher_uart_tx.sv
// Ciphertext UART transmitter: byte FIFO fed from the PicoBlaze output port, 8N1 serialiser, status byte and drained irq.
// Define CIPHER_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module cipher_uart_tx #(
   parameter int          CLKS_PER_BIT = 5208,
   parameter int          FIFO_AW      = 4,
   parameter logic [7:0]  DATA_PORT    = 8'h10,
   parameter logic [7:0]  CTRL_PORT    = 8'h11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       interrupt_ack,
   output logic [7:0] status,
   output logic       irq,
   output logic       tx
);

   // state | meaning
   // IDLE  | line high, waiting for a queued byte
   // START | start bit (low)
   // DATA  | eight data bits, LSB first
   // PARITY| even parity over the data bits (parity build only)
   // STOP  | stop bit (high); chains straight into START if more bytes wait
`ifdef CIPHER_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam int                 DEPTH       = 2**FIFO_AW;
   localparam logic [15:0]        BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   CNT_ONE     = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1);

   state_t               state_q, state_d;
   logic [15:0]          baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 irq_q, irq_d;
   logic                 ovf_q, ovf_d;
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;
   logic [7:0]           mem [DEPTH];
`ifdef CIPHER_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic full, empty, data_wr, ctrl_wr, baud_done, pop, push_ok, irq_set;

   // count never exceeds DEPTH, so its MSB alone marks full
   assign full      = count_q[FIFO_AW];
   assign empty     = (count_q == '0);
   assign data_wr   = write_strobe && (port_id == DATA_PORT);
   assign ctrl_wr   = write_strobe && (port_id == CTRL_PORT);
   assign baud_done = (baud_q == 16'd0);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      irq_d    = irq_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = 1'b0;
      push_ok  = 1'b0;
      irq_set  = 1'b0;
`ifdef CIPHER_TX_PARITY_EN
      parity_d = parity_q;
`endif

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               tx_d    = 1'b0;
               baud_d  = BAUD_RELOAD;
               state_d = START;
            end
         end
         START: begin
            baud_d = baud_q - 16'd1;
            if (baud_done) begin
               baud_d  = BAUD_RELOAD;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            baud_d = baud_q - 16'd1;
            if (baud_done) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
`ifdef CIPHER_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
`ifdef CIPHER_TX_PARITY_EN
         PARITY: begin
            baud_d = baud_q - 16'd1;
            if (baud_done) begin
               baud_d  = BAUD_RELOAD;
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            baud_d = baud_q - 16'd1;
            if (baud_done) begin
               if (!empty) begin
                  pop     = 1'b1;
                  tx_d    = 1'b0;
                  baud_d  = BAUD_RELOAD;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  irq_set = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         shift_d  = mem[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifdef CIPHER_TX_PARITY_EN
         parity_d = ^mem[rd_ptr_q];
`endif
      end

      // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
      push_ok = data_wr && (!full || pop);
      if (data_wr && full && !pop) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;

      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (ctrl_wr && out_port[0]) ovf_d = 1'b0;
      if (ctrl_wr && out_port[1]) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_d;
      end

      if (interrupt_ack)  irq_d = 1'b0;
      else if (irq_set)   irq_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         tx_q     <= 1'b1;
         irq_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
`ifdef CIPHER_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         irq_q    <= irq_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
`ifdef CIPHER_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= out_port;
   end

   assign status = {3'b000, ovf_q, (state_q != IDLE), irq_q, empty, full};
   assign irq    = irq_q;
   assign tx     = tx_q;

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Bench for cipher_uart_tx: a queue-and-frame-timer model predicts tx, status and irq every cycle.
module tb_cipher_uart_tx;

   localparam int         CPB   = 4;
   localparam int         AW    = 2;
   localparam int         DEPTH = 4;
   localparam logic [7:0] DATA  = 8'h10;
   localparam logic [7:0] CTRL  = 8'h11;
`ifdef CIPHER_TX_PARITY_EN
   localparam int         NBITS = 11;
   localparam int         EXPL  = 9;
`else
   localparam int         NBITS = 10;
   localparam int         EXPL  = 10;
`endif
   localparam int         FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       interrupt_ack = 1'b0;
   logic [7:0] status;
   logic       irq;
   logic       tx;

   cipher_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .DATA_PORT(DATA), .CTRL_PORT(CTRL)) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .status(status), .irq(irq), .tx(tx)
   );

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   string cur_test = "none";

   logic [7:0] mq[$];
   bit         m_busy, m_ovf, m_irq;
   int         mc, m_start, m_end;
   logic [7:0] m_cur;

   function automatic logic fbit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef CIPHER_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // One clock cycle: drive inputs, advance the model, compare all outputs just after the edge.
   task automatic step(input logic r, input logic w, input logic [7:0] p, input logic [7:0] d, input logic a);
      bit         fend, pop, set;
      logic       exp_tx;
      logic [7:0] exp_st;
      reset = r; write_strobe = w; port_id = p; out_port = d; interrupt_ack = a;
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         m_busy = 0; m_ovf = 0; m_irq = 0;
      end else begin
         fend = m_busy && (mc == m_end);
         pop  = (mq.size() != 0) && (!m_busy || fend);
         set  = 0;
         if (pop) begin
            m_cur = mq.pop_front();
            m_busy = 1; m_start = mc; m_end = mc + FRAME;
         end else if (fend) begin
            m_busy = 0; set = 1;
         end
         if (a) m_irq = 0;
         else if (set) m_irq = 1;
         if (w && p == DATA) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1;
         end
         if (w && p == CTRL) begin
            if (d[0]) m_ovf = 0;
            if (d[1]) mq.delete();
         end
      end
      mc++;
      reset = 0; write_strobe = 0; interrupt_ack = 0;
      exp_tx = m_busy ? fbit(m_cur, (mc - m_start - 1) / CPB) : 1'b1;
      exp_st = {3'b000, m_ovf, m_busy, m_irq, (mq.size() == 0), (mq.size() == DEPTH)};
      n_vec++;
      if (tx !== exp_tx) begin
         n_err++;
         $display("FAIL %s tx cycle %0d: got %b expected %b", cur_test, mc, tx, exp_tx);
      end
      n_vec++;
      if (status !== exp_st) begin
         n_err++;
         $display("FAIL %s status cycle %0d: got %h expected %h", cur_test, mc, status, exp_st);
      end
      n_vec++;
      if (irq !== m_irq) begin
         n_err++;
         $display("FAIL %s irq cycle %0d: got %b expected %b", cur_test, mc, irq, m_irq);
      end
   endtask

   task automatic idle();          step(0, 0, 8'h00, 8'h00, 0); endtask
   task automatic push(input logic [7:0] d); step(0, 1, DATA, d, 0); endtask
   task automatic ctrl(input logic [7:0] d); step(0, 1, CTRL, d, 0); endtask
   task automatic ack();           step(0, 0, 8'h00, 8'h00, 1); endtask

   task automatic drain();
      int i;
      for (i = 0; i < 1000; i++) begin
         if (!m_busy && mq.size() == 0) break;
         idle();
      end
      n_vec++;
      if (m_busy || mq.size() != 0) begin
         n_err++;
         $display("FAIL %s drain: still busy after %0d cycles, expected idle", cur_test, i);
      end
   endtask

   task automatic test_reset();
      cur_test = "reset";
      step(1, 0, 8'h00, 8'h00, 0);
      step(1, 0, 8'h00, 8'h00, 0);
      n_vec++;
      if (status !== 8'h02 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: status=%h tx=%b expected 02 and 1", status, tx);
      end
      repeat (100) idle();
   endtask

   task automatic test_single();
      int line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      cur_test = "single";
      push(8'hA5);
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL single_pre_start: tx=%b expected 1", tx);
      end
      for (int i = 0; i < FRAME; i++) begin
         idle();
         if (i < EXPL * CPB) begin
            n_vec++;
            if (tx !== line[i / CPB][0]) begin
               n_err++;
               $display("FAIL single_line cycle %0d: tx=%b expected %0d", i, tx, line[i / CPB]);
            end
         end
      end
      idle();
      n_vec++;
      if (irq !== 1'b1 || status !== 8'h06) begin
         n_err++;
         $display("FAIL single_irq: irq=%b status=%h expected 1 and 06", irq, status);
      end
      ack();
      n_vec++;
      if (irq !== 1'b0 || status !== 8'h02) begin
         n_err++;
         $display("FAIL single_ack: irq=%b status=%h expected 0 and 02", irq, status);
      end
   endtask

   task automatic test_back_to_back();
      int  busy_cnt = 0;
      int  irq_rise = 0;
      logic prev_irq = 1'b0;
      cur_test = "back_to_back";
      for (int i = 1; i <= 3; i++) begin
         push(8'(i));
         busy_cnt += int'(status[3]);
      end
      for (int i = 0; i < 4 * FRAME; i++) begin
         idle();
         busy_cnt += int'(status[3]);
         if (irq && !prev_irq) irq_rise++;
         prev_irq = irq;
      end
      n_vec++;
      if (busy_cnt != 3 * FRAME) begin
         n_err++;
         $display("FAIL b2b_busy: busy cycles=%0d expected %0d", busy_cnt, 3 * FRAME);
      end
      n_vec++;
      if (irq_rise != 1) begin
         n_err++;
         $display("FAIL b2b_irq: irq rises=%0d expected 1", irq_rise);
      end
      ack();
   endtask

   task automatic test_overflow();
      cur_test = "overflow";
      for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
      n_vec++;
      if (status[4] !== 1'b1 || status[0] !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_set: status=%h expected overflow and full set", status);
      end
      ctrl(8'h01);
      n_vec++;
      if (status[4] !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_clear: status=%h expected overflow clear", status);
      end
      drain();
      ack();
   endtask

   task automatic test_flush();
      cur_test = "flush";
      for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
      repeat (5) idle();
      ctrl(8'h02);
      n_vec++;
      if (status[1] !== 1'b1 || status[3] !== 1'b1) begin
         n_err++;
         $display("FAIL flush_empty: status=%h expected empty and busy", status);
      end
      drain();
      n_vec++;
      if (status !== 8'h06) begin
         n_err++;
         $display("FAIL flush_done: status=%h expected 06", status);
      end
      ack();
      cur_test = "reset_mid";
      push(8'h00);
      repeat (3 * CPB) idle();
      step(1, 0, 8'h00, 8'h00, 0);
      n_vec++;
      if (tx !== 1'b1 || status !== 8'h02) begin
         n_err++;
         $display("FAIL reset_mid: tx=%b status=%h expected 1 and 02", tx, status);
      end
      repeat (2 * FRAME) idle();
   endtask

`ifdef CIPHER_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] bytes[2] = '{8'h07, 8'h03};
      logic       pbit[2]  = '{1'b1, 1'b0};
      cur_test = "parity";
      for (int j = 0; j < 2; j++) begin
         push(bytes[j]);
         repeat (1 + 9 * CPB + CPB / 2) idle();
         n_vec++;
         if (tx !== pbit[j]) begin
            n_err++;
            $display("FAIL parity_%h: tx=%b expected %b", bytes[j], tx, pbit[j]);
         end
         drain();
         ack();
      end
   endtask
`endif

   task automatic test_random();
      int r;
      logic [7:0] d;
      cur_test = "random";
      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 99));
         d = 8'($urandom_range(0, 255));
         if (r < 35)      step(0, 1, DATA, d, ($urandom_range(0, 19) == 0));
         else if (r < 38) step(0, 1, CTRL, {6'h00, ($urandom_range(0, 9) == 0), d[0]}, 0);
         else if (r < 43) step(0, 1, 8'h12, d, 0);
         else             step(0, 0, 8'h00, d, ($urandom_range(0, 19) == 0));
      end
      drain();
      ack();
   endtask

   initial begin
      mc = 0; m_start = 0; m_end = 0; m_cur = 8'h00;
      m_busy = 0; m_ovf = 0; m_irq = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_flush();
`ifdef CIPHER_TX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
